memory_controller: RTL and testbench

//  Sole owner of the byte-wide synchronous RAM port. Arbitrates between instruction fetch
//  (32-bit word reads) and the load/store buffer (LB/LH/LW/LBU/LHU/SB/SH/SW).

---
 rtl/memory_controller_if.sv | 39 +++
 rtl/memory_controller.sv | 156 +++++++++++++++
 tb/tb_memory_controller.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_controller_if.sv
// Bus bundle between memory_controller and its environment: RAM port, fetch port, LSB port.
// The controller uses the slave modport; the environment drives through master.
interface memory_controller_if #(
  parameter int ADDR_W = 32,
  parameter int TYPE_W = 4
) ();
  logic              rdy_in;
  logic              flush;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic              io_buffer_full;
  logic              if_en;
  logic [ADDR_W-1:0] if_addr;
  logic              if_rdy;
  logic [31:0]       if_data;
  logic              lsb_en;
  logic [ADDR_W-1:0] lsb_addr;
  logic [TYPE_W-1:0] lsb_type;
  logic [31:0]       lsb_write_data;
  logic              lsb_rdy;
  logic [31:0]       lsb_read_data;
  logic [1:0]        state_dbg;

  // Requests are level-held by the requester and taken on the IDLE edge where the
  // controller accepts; completion is a single-cycle if_rdy/lsb_rdy pulse with data valid.
  modport slave (
    input  rdy_in, flush, mem_din, io_buffer_full,
    input  if_en, if_addr, lsb_en, lsb_addr, lsb_type, lsb_write_data,
    output mem_dout, mem_a, mem_wr, if_rdy, if_data, lsb_rdy, lsb_read_data, state_dbg
  );

  modport master (
    output rdy_in, flush, mem_din, io_buffer_full,
    output if_en, if_addr, lsb_en, lsb_addr, lsb_type, lsb_write_data,
    input  mem_dout, mem_a, mem_wr, if_rdy, if_data, lsb_rdy, lsb_read_data, state_dbg
  );
endinterface

// File: rtl/memory_controller.sv
// memory_controller: owns the byte-wide RAM port, serialising fetch and LSB accesses into bytes.
// Optional MC_IO_GUARD_EN: store bytes to addr[17:16]==2'b11 stall while io_buffer_full is high.
module memory_controller #(
  parameter int ADDR_W = 32,
  parameter int TYPE_W = 4
) (
  input logic clk_in,
  input logic rst_in,
  memory_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} state_t;

  state_t            state_q;
  logic [2:0]        cnt_q;
  logic              is_lsb_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] mem_a_q;
  logic [2:0]        type_q;
  logic [31:0]       wdata_q;
  logic [23:0]       rbuf_q;
  logic [7:0]        mem_dout_q;
  logic              mem_wr_q;
  logic              if_rdy_q;
  logic              lsb_rdy_q;
  logic [31:0]       if_data_q;
  logic [31:0]       lsb_rdata_q;

  logic [TYPE_W-1:0] req_type;
  logic [2:0]        n_bytes;
  logic [2:0]        cnt_inc;
  logic [31:0]       wshift;
  logic [31:0]       assembled;
  logic [31:0]       load_val;
  logic              stall;

  assign req_type = bus.lsb_type;

  always_comb begin
    n_bytes = 3'd4;
    case (type_q[1:0])
      2'd0:    n_bytes = 3'd1;
      2'd1:    n_bytes = 3'd2;
      default: n_bytes = 3'd4;
    endcase
    cnt_inc = cnt_q + 3'd1;
    wshift  = wdata_q >> {cnt_inc, 3'b000};
    // Bytes shift in from the top, so the newest byte is always assembled[31:24].
    assembled = {bus.mem_din, rbuf_q};
    case (type_q[1:0])
      2'd0:    load_val = type_q[2] ? {24'd0, assembled[31:24]}
                                    : {{24{assembled[31]}}, assembled[31:24]};
      2'd1:    load_val = type_q[2] ? {16'd0, assembled[31:16]}
                                    : {{16{assembled[31]}}, assembled[31:16]};
      default: load_val = assembled;
    endcase
`ifdef MC_IO_GUARD_EN
    stall = (state_q == WRITE) && (mem_a_q[17:16] == 2'b11) && bus.io_buffer_full;
`else
    stall = 1'b0;
`endif
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      is_lsb_q    <= 1'b0;
      addr_q      <= '0;
      mem_a_q     <= '0;
      type_q      <= 3'd0;
      wdata_q     <= 32'd0;
      rbuf_q      <= 24'd0;
      mem_dout_q  <= 8'd0;
      mem_wr_q    <= 1'b0;
      if_rdy_q    <= 1'b0;
      lsb_rdy_q   <= 1'b0;
      if_data_q   <= 32'd0;
      lsb_rdata_q <= 32'd0;
    end else if (bus.rdy_in) begin
      if_rdy_q  <= 1'b0;
      lsb_rdy_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // The rdy cycle doubles as a bubble so a held request is not re-taken.
          if (!bus.flush && !if_rdy_q && !lsb_rdy_q) begin
            if (bus.lsb_en) begin
              is_lsb_q <= 1'b1;
              addr_q   <= bus.lsb_addr;
              mem_a_q  <= bus.lsb_addr;
              type_q   <= req_type[2:0];
              wdata_q  <= bus.lsb_write_data;
              cnt_q    <= 3'd0;
              if (req_type[3]) begin
                state_q    <= WRITE;
                mem_wr_q   <= 1'b1;
                mem_dout_q <= bus.lsb_write_data[7:0];
              end else begin
                state_q <= READ;
              end
            end else if (bus.if_en) begin
              is_lsb_q <= 1'b0;
              addr_q   <= bus.if_addr;
              mem_a_q  <= bus.if_addr;
              type_q   <= 3'b010;
              cnt_q    <= 3'd0;
              state_q  <= READ;
            end
          end
        end
        READ: begin
          if (bus.flush) begin
            state_q <= IDLE;
          end else begin
            if (cnt_q != 3'd0) rbuf_q <= {bus.mem_din, rbuf_q[23:8]};
            if (cnt_q == n_bytes) begin
              state_q <= IDLE;
              if (is_lsb_q) begin
                lsb_rdata_q <= load_val;
                lsb_rdy_q   <= 1'b1;
              end else begin
                if_data_q <= load_val;
                if_rdy_q  <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_inc;
              if (cnt_inc < n_bytes) mem_a_q <= addr_q + ADDR_W'(cnt_inc);
            end
          end
        end
        WRITE: begin
          if (!stall) begin
            if (cnt_q == n_bytes - 3'd1) begin
              state_q   <= IDLE;
              mem_wr_q  <= 1'b0;
              lsb_rdy_q <= 1'b1;
            end else begin
              cnt_q      <= cnt_inc;
              mem_a_q    <= addr_q + ADDR_W'(cnt_inc);
              mem_dout_q <= wshift[7:0];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_a         = mem_a_q;
  assign bus.mem_dout      = mem_dout_q;
  assign bus.mem_wr        = mem_wr_q & bus.rdy_in & ~stall;
  assign bus.if_rdy        = if_rdy_q;
  assign bus.if_data       = if_data_q;
  assign bus.lsb_rdy       = lsb_rdy_q;
  assign bus.lsb_read_data = lsb_rdata_q;
  assign bus.state_dbg     = state_q;
endmodule

// File: tb/tb_memory_controller.sv
// Bench for memory_controller: directed cases plus random traffic against a byte-array reference memory.
module tb_memory_controller;
  localparam logic [3:0] T_LB = 4'b0000, T_LH = 4'b0001, T_LW = 4'b0010;
  localparam logic [3:0] T_LBU = 4'b0100, T_LHU = 4'b0101;
  localparam logic [3:0] T_SB = 4'b1000, T_SH = 4'b1001, T_SW = 4'b1010;

  logic clk_in;
  logic rst_in;
  memory_controller_if #(.ADDR_W(32), .TYPE_W(4)) bus ();

  memory_controller #(.ADDR_W(32), .TYPE_W(4)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int n_checks;
  int n_fail;
  logic [7:0]  ram     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [31:0] exp_if_q[$];
  logic [32:0] exp_lsb_q[$];
  logic [39:0] exp_wr_q[$];

  // ---------------- clock / reset ----------------
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  // Synchronous RAM: read data appears one cycle after the address is sampled.
  always @(posedge clk_in) begin
    if (bus.mem_wr) ram[bus.mem_a[15:0]] <= bus.mem_dout;
    bus.mem_din <= ram[bus.mem_a[15:0]];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_load(input logic [31:0] a, input int nb, input bit uns);
    logic [31:0] v;
    logic [31:0] ai;
    v = 32'd0;
    for (int i = 0; i < nb; i++) begin
      ai = a + 32'(i);
      v = v | (32'(ref_mem[ai[15:0]]) << (8 * i));
    end
    if (nb == 1 && !uns) v = 32'($signed(v[7:0]));
    if (nb == 2 && !uns) v = 32'($signed(v[15:0]));
    return v;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_in) begin
    logic [31:0] e32;
    logic [32:0] e33;
    logic [39:0] e40;
    if (!rst_in) begin
      if (bus.if_rdy) begin
        if (exp_if_q.size() == 0) check("if_rdy_unexpected", 1, 0);
        else begin
          e32 = exp_if_q.pop_front();
          check("if_data", bus.if_data, e32);
        end
      end
      if (bus.lsb_rdy) begin
        if (exp_lsb_q.size() == 0) check("lsb_rdy_unexpected", 1, 0);
        else begin
          e33 = exp_lsb_q.pop_front();
          if (!e33[32]) check("lsb_read_data", bus.lsb_read_data, e33[31:0]);
        end
      end
      if (bus.mem_wr) begin
        if (exp_wr_q.size() == 0) check("mem_wr_unexpected", 1, 0);
        else begin
          e40 = exp_wr_q.pop_front();
          check("wr_addr", bus.mem_a, e40[39:8]);
          check("wr_data", bus.mem_dout, e40[7:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic access(input bit fetch, input logic [31:0] addr, input logic [3:0] typ,
                        input logic [31:0] wd, input int flush_at, input int hold_at,
                        input int io_stall, input string name);
    int nb;
    bit store;
    bit aborted;
    int exp_lat;
    int lat;
    bit got;
    logic [31:0] ai;
    nb      = fetch ? 4 : (1 << typ[1:0]);
    store   = !fetch && typ[3];
    aborted = !store && flush_at >= 0 && flush_at <= nb;
    if (!aborted) begin
      if (store) begin
        for (int i = 0; i < nb; i++) begin
          ai = addr + 32'(i);
          exp_wr_q.push_back({ai, wd[8*i +: 8]});
          ref_mem[ai[15:0]] = wd[8*i +: 8];
        end
        exp_lsb_q.push_back({1'b1, 32'd0});
      end else if (fetch) exp_if_q.push_back(ref_load(addr, 4, 1'b0));
      else exp_lsb_q.push_back({1'b0, ref_load(addr, nb, typ[2])});
    end
    exp_lat = (store ? nb + io_stall : nb + 1) + (hold_at >= 0 ? 2 : 0);
    @(posedge clk_in); #1;
    if (fetch) begin
      bus.if_en = 1'b1; bus.if_addr = addr;
    end else begin
      bus.lsb_en = 1'b1; bus.lsb_addr = addr; bus.lsb_type = typ; bus.lsb_write_data = wd;
    end
    @(posedge clk_in); #1;
    bus.if_en = 1'b0; bus.lsb_en = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      bus.flush          = (lat == flush_at);
      bus.rdy_in         = !(hold_at >= 0 && lat >= hold_at && lat < hold_at + 2);
      bus.io_buffer_full = (lat < io_stall);
      @(negedge clk_in);
      if (lat < io_stall) check({name, "_stall_wr"}, bus.mem_wr, 0);
      if (aborted && lat == 2) check({name, "_idle_after_flush"}, bus.state_dbg, 0);
      if (fetch ? bus.if_rdy : bus.lsb_rdy) got = 1'b1;
      else begin
        @(posedge clk_in); #1;
        lat++;
      end
    end
    bus.flush = 1'b0; bus.rdy_in = 1'b1; bus.io_buffer_full = 1'b0;
    if (aborted) check({name, "_no_rdy"}, got, 0);
    else check({name, "_latency"}, lat, exp_lat);
  endtask

  task automatic wait_rdy(input bit fetch, output int lat);
    lat = 0;
    forever begin
      @(negedge clk_in);
      if ((fetch ? bus.if_rdy : bus.lsb_rdy) || lat >= 20) break;
      @(posedge clk_in); #1;
      lat++;
    end
  endtask

  task automatic contention(input logic [31:0] la, input logic [31:0] fa);
    int lat;
    exp_lsb_q.push_back({1'b0, ref_load(la, 4, 1'b0)});
    exp_if_q.push_back(ref_load(fa, 4, 1'b0));
    @(posedge clk_in); #1;
    bus.lsb_en = 1'b1; bus.lsb_addr = la; bus.lsb_type = T_LW;
    bus.if_en  = 1'b1; bus.if_addr  = fa;
    @(posedge clk_in); #1;
    bus.lsb_en = 1'b0;
    wait_rdy(1'b0, lat);
    check("contend_lsb_first_latency", lat, 5);
    @(posedge clk_in); #1;
    check("contend_bubble_idle", bus.state_dbg, 0);
    @(posedge clk_in); #1;
    bus.if_en = 1'b0;
    wait_rdy(1'b1, lat);
    check("contend_fetch_latency", lat, 5);
  endtask

  task automatic flush_idle_request();
    int rdy_seen;
    rdy_seen = 0;
    @(posedge clk_in); #1;
    bus.lsb_en = 1'b1; bus.lsb_addr = 32'h200; bus.lsb_type = T_LB; bus.flush = 1'b1;
    @(posedge clk_in); #1;
    bus.lsb_en = 1'b0; bus.flush = 1'b0;
    check("flush_idle_state", bus.state_dbg, 0);
    repeat (8) begin
      @(negedge clk_in);
      if (bus.lsb_rdy) rdy_seen++;
    end
    check("flush_idle_no_rdy", rdy_seen, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0]  types [8];
    logic [31:0] a;
    logic [31:0] wd;
    int k;
    int hold;
    types = '{T_LB, T_LH, T_LW, T_LBU, T_LHU, T_SB, T_SH, T_SW};
    n_checks = 0; n_fail = 0;
    for (int i = 0; i < 65536; i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[16'h100] = 8'h13; ram[16'h101] = 8'h05; ram[16'h102] = 8'h00; ram[16'h103] = 8'h00;
    ram[16'h200] = 8'h80;
    for (int i = 16'h100; i < 16'h104; i++) ref_mem[i] = ram[i];
    ref_mem[16'h200] = 8'h80;

    rst_in = 1'b1;
    bus.rdy_in = 1'b1; bus.flush = 1'b0; bus.io_buffer_full = 1'b0;
    bus.if_en = 1'b0; bus.if_addr = '0; bus.lsb_en = 1'b0; bus.lsb_addr = '0;
    bus.lsb_type = '0; bus.lsb_write_data = '0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_mem_a", bus.mem_a, 0);
    check("rst_mem_dout", bus.mem_dout, 0);
    check("rst_mem_wr", bus.mem_wr, 0);
    check("rst_if_rdy", bus.if_rdy, 0);
    check("rst_lsb_rdy", bus.lsb_rdy, 0);
    check("rst_if_data", bus.if_data, 0);
    check("rst_lsb_read_data", bus.lsb_read_data, 0);
    check("rst_state", bus.state_dbg, 0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;

    access(1'b1, 32'h100, T_LW, 0, -1, -1, 0, "fetch_0x100");
    access(1'b0, 32'h200, T_LB, 0, -1, -1, 0, "lb_0x200");
    access(1'b0, 32'h200, T_LBU, 0, -1, -1, 0, "lbu_0x200");
    access(1'b0, 32'h300, T_SW, 32'hDEADBEEF, -1, -1, 0, "sw_0x300");
    access(1'b0, 32'h300, T_LW, 0, -1, -1, 0, "lw_0x300");
    contention(32'h300, 32'h100);
    access(1'b1, 32'h100, T_LW, 0, 1, -1, 0, "fetch_flush");
    access(1'b0, 32'h400, T_SH, 32'h0000A5C3, 1, -1, 0, "sh_flush");
    access(1'b0, 32'h400, T_LHU, 0, -1, -1, 0, "lhu_0x400");
    access(1'b0, 32'h500, T_SW, 32'h12345678, -1, 1, 0, "sw_rdy_hold");
    access(1'b0, 32'h502, T_LH, 0, -1, -1, 0, "lh_0x502");
    flush_idle_request();
`ifdef MC_IO_GUARD_EN
    access(1'b0, 32'h30000, T_SB, 32'h0000005A, -1, -1, 3, "sb_io_guard");
    access(1'b0, 32'h30000, T_LBU, 0, -1, -1, 0, "lbu_io_region");
`endif

    for (int t = 0; t < 60; t++) begin
      k  = $urandom_range(0, 8);
      a  = (t % 10 == 0) ? 32'h0000FFFD : 32'($urandom_range(0, 2047));
      wd = $urandom;
      if (k == 8) access(1'b1, a, T_LW, 0, -1, -1, 0, "rnd_fetch");
      else begin
        hold = -1;
        if (types[k][3] && $urandom_range(0, 3) == 0)
          hold = $urandom_range(0, (1 << types[k][1:0]) - 1);
        access(1'b0, a, types[k], wd, -1, hold, 0, "rnd_lsb");
      end
    end

    repeat (10) @(negedge clk_in);
    check("if_queue_drained", exp_if_q.size(), 0);
    check("lsb_queue_drained", exp_lsb_q.size(), 0);
    check("wr_queue_drained", exp_wr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
